jellyvl_periodic_trigger_monitor: RTL and testbench
===================================================

JELLYVL_PERIODIC_TRIGGER_MONITOR -- requirements
Module: jellyvl_periodic_trigger_monitor

Interface
REQ-001 The block SHALL have parameter TIMER_WIDTH, default 64, the width of the free-running time base.
REQ-002 The block SHALL have parameter PERIOD_WIDTH, default 32, the width of period, tolerance and elapsed-time arithmetic.
REQ-003 The block SHALL have parameter LOCK_COUNT, default 4, the number of consecutive in-tolerance triggers required to declare lock (range 1..255).
REQ-004 The block SHALL have parameter MISS_LIMIT, default 3, the number of consecutive missing triggers that returns tracking to acquisition (range 1..255).
REQ-005 Ports SHALL be as follows; one clock; reset is asynchronous and active-low:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  monitor enable; 0 forces IDLE
- period  in  PERIOD_WIDTH  expected trigger period, in timer ticks
- tolerance  in  PERIOD_WIDTH  allowed deviation from period, in ticks
- current_time  in  TIMER_WIDTH  time base shared with the trigger generator
- trigger  in  1  single-cycle trigger pulse under observation
- last_time  out  TIMER_WIDTH  current_time captured at the last accepted trigger
- measured_period  out  PERIOD_WIDTH  last trigger-to-trigger interval
- period_valid  out  1  one-cycle pulse when measured_period updates
- locked  out  1  high in LOCKED state
- early  out  1  one-cycle pulse, trigger arrived before window
- late  out  1  one-cycle pulse, trigger arrived after window
- missing  out  1  one-cycle pulse, window expired with no trigger
- miss_count  out  16  saturating count of missing events
- err_count  out  16  saturating count of early plus late events

Function
REQ-006 The block SHALL compute elapsed = current_time[PERIOD_WIDTH-1:0] - base_time, modulo 2^PERIOD_WIDTH, so that time-base wrap is transparent.
REQ-007 Window bounds SHALL be computed in PERIOD_WIDTH+1 bits: lo = period - tolerance, clamped to 0; hi = period + tolerance, without overflow.
REQ-008 The state machine SHALL have the states IDLE, ACQUIRE, TRACK and LOCKED.
REQ-009 When enable=0, the block SHALL enter IDLE and drive all pulses and locked to 0; measured_period, last_time and the counters SHALL hold their values.
REQ-010 In IDLE with enable=1, the block SHALL go to ACQUIRE on the next edge.
REQ-011 In ACQUIRE, on trigger: base_time and last_time SHALL take current_time; lock_cnt and miss_run SHALL clear; the state SHALL go to TRACK; no period_valid is issued.
REQ-012 In TRACK or LOCKED, on trigger, the block SHALL register measured_period = elapsed, pulse period_valid, and set base_time and last_time to current_time, all on the next edge.
REQ-013 A trigger with lo <= elapsed <= hi SHALL clear miss_run and increment lock_cnt, saturating; when lock_cnt reaches LOCK_COUNT, the state SHALL go to LOCKED.
REQ-014 A trigger with elapsed < lo SHALL pulse early; a trigger with elapsed > hi SHALL pulse late; either case SHALL clear lock_cnt and set the state to TRACK.
REQ-015 In TRACK or LOCKED, with no trigger and elapsed > hi, the block SHALL:
- pulse missing;
- advance base_time by period (flywheel);
- clear lock_cnt and increment miss_run;
- set the state to TRACK, or to ACQUIRE if miss_run reaches MISS_LIMIT.
REQ-016 Simultaneous trigger and window expiry SHALL be treated as a late trigger (REQ-014) and SHALL NOT also pulse missing.
REQ-017 A trigger arriving while in IDLE SHALL be ignored.
REQ-018 All outputs SHALL be registered, with a latency of 1 clk from trigger or expiry to output.
REQ-019 period and tolerance SHALL be sampled every cycle; changing them mid-operation SHALL take effect on the next comparison, with no other side effect.

Reset
REQ-020 On reset_n=0, the block SHALL asynchronously enter IDLE and clear every output, plus base_time, lock_cnt and miss_run.
REQ-021 On reset_n deassertion mid-stream, the block SHALL restart at IDLE, and the first trigger SHALL be handled per REQ-011.

Configuration
REQ-022 When macro JELLYVL_PERIODIC_TRIGGER_MONITOR_STATS_EN is defined:
- miss_count SHALL increment on each missing pulse;
- err_count SHALL increment on each early or late pulse;
- both SHALL saturate at 16'hFFFF and clear only on reset.
REQ-023 When JELLYVL_PERIODIC_TRIGGER_MONITOR_STATS_EN is undefined, miss_count and err_count SHALL be constant 0 and no counter registers SHALL exist.

Verification
REQ-024 Bench scenario, lock-in: period=100, tolerance=2, triggers every 100 ticks -> period_valid with measured_period=100 from the 2nd trigger; locked rises after the 5th trigger (LOCK_COUNT=4).
REQ-025 Bench scenario, drop: locked, one trigger omitted -> missing pulse at elapsed=103; locked falls; the next on-time trigger is measured_period=100 from the flywheeled base, with no error.
REQ-026 Bench scenario, early: trigger at elapsed=90 -> early pulse, measured_period=90, state TRACK, err_count=1 with STATS_EN.
REQ-027 Bench scenario, loss: 3 consecutive missing triggers -> state ACQUIRE; the next trigger produces no period_valid.
REQ-028 Bench scenario, wrap: PERIOD_WIDTH=8, current_time crossing 255->0 with period=100 -> measured_period=100, no error pulses.
REQ-029 Bench scenario, reset/disable: reset_n low mid-LOCKED -> all outputs 0 immediately; enable=0 -> locked=0 and measured_period retained.

Source files
------------

// File: rtl/jellyvl_periodic_trigger_monitor.sv
// Periodic trigger monitor: measures trigger-to-trigger interval, flags early/late/missing, declares lock.
// Optional statistics counters are enabled by macro JELLYVL_PERIODIC_TRIGGER_MONITOR_STATS_EN.
module jellyvl_periodic_trigger_monitor #(
  parameter int TIMER_WIDTH  = 64,
  parameter int PERIOD_WIDTH = 32,
  parameter int LOCK_COUNT   = 4,
  parameter int MISS_LIMIT   = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic [PERIOD_WIDTH-1:0] tolerance,
  input  logic [TIMER_WIDTH-1:0]  current_time,
  input  logic                    trigger,
  output logic [TIMER_WIDTH-1:0]  last_time,
  output logic [PERIOD_WIDTH-1:0] measured_period,
  output logic                    period_valid,
  output logic                    locked,
  output logic                    early,
  output logic                    late,
  output logic                    missing,
  output logic [15:0]             miss_count,
  output logic [15:0]             err_count
);

  // state   | meaning
  // IDLE    | disabled or just out of reset
  // ACQUIRE | waiting for a first trigger to set the base time
  // TRACK   | measuring intervals, not yet locked
  // LOCKED  | LOCK_COUNT consecutive in-window triggers seen
  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} state_t;

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] base_time;
  logic [PERIOD_WIDTH-1:0] elapsed;
  logic [PERIOD_WIDTH:0]   elapsed_x;
  logic [PERIOD_WIDTH:0]   lo;
  logic [PERIOD_WIDTH:0]   hi;
  logic [7:0]              lock_cnt;
  logic [7:0]              miss_run;
  logic [7:0]              lock_inc;
  logic [7:0]              miss_inc;
  logic                    tracking;
  logic                    is_early;
  logic                    is_late;
  logic                    ev_trig;
  logic                    ev_err;
  logic                    ev_miss;

  // Modular subtraction keeps time-base wrap transparent.
  assign elapsed   = current_time[PERIOD_WIDTH-1:0] - base_time;
  assign elapsed_x = {1'b0, elapsed};
  assign lo        = (tolerance > period) ? '0 : ({1'b0, period} - {1'b0, tolerance});
  assign hi        = {1'b0, period} + {1'b0, tolerance};
  assign is_early  = elapsed_x < lo;
  assign is_late   = elapsed_x > hi;
  assign lock_inc  = (lock_cnt == 8'hFF) ? lock_cnt : lock_cnt + 8'd1;
  assign miss_inc  = (miss_run == 8'hFF) ? miss_run : miss_run + 8'd1;

  assign tracking = enable && ((state == TRACK) || (state == LOCKED));
  assign ev_trig  = tracking && trigger;
  assign ev_err   = ev_trig && (is_early || is_late);
  // A trigger coinciding with expiry is late, never also missing.
  assign ev_miss  = tracking && !trigger && is_late;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      base_time       <= '0;
      lock_cnt        <= '0;
      miss_run        <= '0;
      last_time       <= '0;
      measured_period <= '0;
      period_valid    <= 1'b0;
      locked          <= 1'b0;
      early           <= 1'b0;
      late            <= 1'b0;
      missing         <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      early        <= 1'b0;
      late         <= 1'b0;
      missing      <= 1'b0;
      locked       <= (state == LOCKED);
      if (!enable) begin
        state  <= IDLE;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state  <= ACQUIRE;
            locked <= 1'b0;
          end
          ACQUIRE: begin
            locked <= 1'b0;
            if (trigger) begin
              base_time <= current_time[PERIOD_WIDTH-1:0];
              last_time <= current_time;
              lock_cnt  <= '0;
              miss_run  <= '0;
              state     <= TRACK;
            end
          end
          TRACK, LOCKED: begin
            if (trigger) begin
              measured_period <= elapsed;
              period_valid    <= 1'b1;
              base_time       <= current_time[PERIOD_WIDTH-1:0];
              last_time       <= current_time;
              if (is_early || is_late) begin
                early    <= is_early;
                late     <= is_late;
                lock_cnt <= '0;
                state    <= TRACK;
                locked   <= 1'b0;
              end else begin
                miss_run <= '0;
                lock_cnt <= lock_inc;
                if (lock_inc >= 8'(LOCK_COUNT)) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end else begin
                  state  <= TRACK;
                  locked <= 1'b0;
                end
              end
            end else if (is_late) begin
              // Flywheel: keep the expected phase even though the trigger was lost.
              missing   <= 1'b1;
              base_time <= base_time + period;
              lock_cnt  <= '0;
              miss_run  <= miss_inc;
              locked    <= 1'b0;
              state     <= (miss_inc >= 8'(MISS_LIMIT)) ? ACQUIRE : TRACK;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef JELLYVL_PERIODIC_TRIGGER_MONITOR_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miss_count <= '0;
      err_count  <= '0;
    end else begin
      if (ev_miss && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
      if (ev_err && (err_count != 16'hFFFF))   err_count  <= err_count + 16'd1;
    end
  end
`else
  assign miss_count = '0;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_jellyvl_periodic_trigger_monitor.sv
// Bench for jellyvl_periodic_trigger_monitor: directed scenarios plus randomized triggers,
// checked every cycle against a behavioural model (8-bit period arithmetic so wrap is exercised constantly).
module tb_jellyvl_periodic_trigger_monitor;

  localparam int TW = 16;
  localparam int PW = 8;
  localparam int M_IDLE = 0, M_ACQ = 1, M_TRACK = 2, M_LOCKED = 3;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [PW-1:0] period;
  logic [PW-1:0] tolerance;
  logic [TW-1:0] current_time;
  logic          trigger;
  logic [TW-1:0] last_time;
  logic [PW-1:0] measured_period;
  logic          period_valid;
  logic          locked;
  logic          early;
  logic          late;
  logic          missing;
  logic [15:0]   miss_count;
  logic [15:0]   err_count;

  jellyvl_periodic_trigger_monitor #(
    .TIMER_WIDTH(TW), .PERIOD_WIDTH(PW), .LOCK_COUNT(4), .MISS_LIMIT(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .period(period),
    .tolerance(tolerance), .current_time(current_time), .trigger(trigger),
    .last_time(last_time), .measured_period(measured_period),
    .period_valid(period_valid), .locked(locked), .early(early), .late(late),
    .missing(missing), .miss_count(miss_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ct       = 0;

  // Behavioural reference
  int m_mode, m_base, m_locks, m_misses;
  int e_last, e_meas, e_mc, e_ec;
  bit e_pv, e_early, e_late, e_miss, e_locked;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_base = 0; m_locks = 0; m_misses = 0;
    e_last = 0; e_meas = 0; e_mc = 0; e_ec = 0;
    e_pv = 0; e_early = 0; e_late = 0; e_miss = 0; e_locked = 0;
  endtask

  task automatic model_step(input bit trig);
    int el, lo, hi, p, t;
    e_pv = 0; e_early = 0; e_late = 0; e_miss = 0;
    p  = int'(period);
    t  = int'(tolerance);
    lo = (p > t) ? p - t : 0;
    hi = p + t;
    el = ((ct % 256) - m_base + 256) % 256;
    if (!enable) m_mode = M_IDLE;
    else if (m_mode == M_IDLE) m_mode = M_ACQ;
    else if (m_mode == M_ACQ) begin
      if (trig) begin
        m_base = ct % 256; e_last = ct; m_locks = 0; m_misses = 0; m_mode = M_TRACK;
      end
    end else if (trig) begin
      e_meas = el; e_pv = 1; m_base = ct % 256; e_last = ct;
      if (el < lo || el > hi) begin
        e_early = (el < lo); e_late = (el > hi);
        m_locks = 0; m_mode = M_TRACK;
`ifdef JELLYVL_PERIODIC_TRIGGER_MONITOR_STATS_EN
        if (e_ec < 65535) e_ec++;
`endif
      end else begin
        m_misses = 0;
        if (m_locks < 255) m_locks++;
        m_mode = (m_locks >= 4) ? M_LOCKED : M_TRACK;
      end
    end else if (el > hi) begin
      e_miss = 1;
      m_base = (m_base + p) % 256;
      m_locks = 0;
      if (m_misses < 255) m_misses++;
      m_mode = (m_misses >= 3) ? M_ACQ : M_TRACK;
`ifdef JELLYVL_PERIODIC_TRIGGER_MONITOR_STATS_EN
      if (e_mc < 65535) e_mc++;
`endif
    end
    e_locked = (m_mode == M_LOCKED);
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".locked"},          64'(locked),          64'(e_locked));
    chk({ctx, ".period_valid"},    64'(period_valid),    64'(e_pv));
    chk({ctx, ".early"},           64'(early),           64'(e_early));
    chk({ctx, ".late"},            64'(late),            64'(e_late));
    chk({ctx, ".missing"},         64'(missing),         64'(e_miss));
    chk({ctx, ".measured_period"}, 64'(measured_period), 64'(e_meas));
    chk({ctx, ".last_time"},       64'(last_time),       64'(e_last));
    chk({ctx, ".miss_count"},      64'(miss_count),      64'(e_mc));
    chk({ctx, ".err_count"},       64'(err_count),       64'(e_ec));
  endtask

  task automatic cycle(input bit trig);
    trigger = trig;
    @(posedge clk);
    model_step(trig);
    #1;
    check_all("cyc");
    ct = (ct + 1) % 65536;
    current_time = TW'(ct);
    trigger = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n - 1) cycle(1'b0);
    cycle(1'b1);
  endtask

  initial begin
    int cd;
    reset_n = 1'b0; enable = 1'b0; period = 8'd100; tolerance = 8'd2;
    trigger = 1'b0; current_time = '0;
    model_reset();
    #3;
    check_all("reset");
    #10 reset_n = 1'b1;
    enable = 1'b1;
    cycle(1'b0);
    cycle(1'b0);

    // Lock-in: also crosses the 8-bit wrap between the 3rd and 4th triggers.
    cycle(1'b1);
    gap(100);
    chk("lockin_meas2", 64'(measured_period), 64'd100);
    chk("lockin_pv2", 64'(period_valid), 64'd1);
    repeat (3) gap(100);
    chk("lockin_locked", 64'(locked), 64'd1);

    // Drop one trigger.
    repeat (103) cycle(1'b0);
    chk("drop_missing", 64'(missing), 64'd1);
    chk("drop_unlocked", 64'(locked), 64'd0);
    repeat (96) cycle(1'b0);
    cycle(1'b1);
    chk("drop_meas", 64'(measured_period), 64'd100);
    chk("drop_no_late", 64'(late), 64'd0);

    // Early trigger.
    gap(90);
    chk("early_pulse", 64'(early), 64'd1);
    chk("early_meas", 64'(measured_period), 64'd90);
`ifdef JELLYVL_PERIODIC_TRIGGER_MONITOR_STATS_EN
    chk("early_err_count", 64'(err_count), 64'd1);
`else
    chk("early_err_count", 64'(err_count), 64'd0);
`endif

    // Loss: three flywheel misses return to acquisition.
    repeat (310) cycle(1'b0);
    cycle(1'b1);
    chk("loss_no_pv", 64'(period_valid), 64'd0);
    gap(100);
    chk("loss_reacq_meas", 64'(measured_period), 64'd100);

    // Tolerance larger than period clamps the low bound to 0.
    period = 8'd30; tolerance = 8'd40;
    gap(5);
    chk("clamp_no_early", 64'(early), 64'd0);

    // Randomized phase.
    cd = 50;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        period    = 8'($urandom_range(20, 120));
        tolerance = 8'($urandom_range(0, 130));
      end
      if ($urandom_range(0, 399) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
      cd--;
      if (cd <= 0) begin
        cycle(1'b1);
        cd = int'(period) + int'($urandom_range(0, 16)) - 8;
      end else cycle(1'b0);
    end

    // Reset mid-LOCKED.
    enable = 1'b1; period = 8'd100; tolerance = 8'd2;
    cycle(1'b0); cycle(1'b0);
    cycle(1'b1);
    repeat (6) gap(100);
    chk("relock_locked", 64'(locked), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    chk("async_reset_locked", 64'(locked), 64'd0);
    #2 reset_n = 1'b1;
    cycle(1'b0); cycle(1'b0);
    cycle(1'b1);
    chk("post_reset_no_pv", 64'(period_valid), 64'd0);
    gap(100);
    chk("post_reset_meas", 64'(measured_period), 64'd100);

    // Disable while locked.
    repeat (4) gap(100);
    chk("dis_pre_locked", 64'(locked), 64'd1);
    enable = 1'b0;
    cycle(1'b0);
    chk("dis_locked", 64'(locked), 64'd0);
    chk("dis_meas_hold", 64'(measured_period), 64'd100);
    repeat (3) cycle(1'b1);
    enable = 1'b1;
    repeat (3) cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
